// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcode field layout, opcode constants and
// the fetch FSM state type.
package cpu_pkg;

    localparam int ADDR_W = 14;
    localparam int INS_W  = 19;

    localparam int OPC_HI = 18;
    localparam int OPC_LO = 14;
    localparam int OPC_W  = OPC_HI - OPC_LO + 1;

    localparam logic [OPC_W-1:0] OPC_NOP  = 5'h00;
    localparam logic [OPC_W-1:0] OPC_LOAD = 5'h01;
    localparam logic [OPC_W-1:0] OPC_STOR = 5'h02;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'h03;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'h04;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'h05;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'h06;
    localparam logic [OPC_W-1:0] OPC_XOR  = 5'h07;
    localparam logic [OPC_W-1:0] OPC_JMP  = 5'h08;
    localparam logic [OPC_W-1:0] OPC_BRZ  = 5'h09;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'h1F;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INS_W-1:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter: wrapping increment and redirect target selection.
// With FETCH_BRANCH_EN defined, a relative branch joins the redirect mux.
module fetch_pc #(
    parameter int          ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
`ifdef FETCH_BRANCH_EN
    input  logic              branch_taken,
    input  logic [5:0]        branch_offset,
    input  logic [ADDR_W-1:0] branch_base,
`endif
    output logic              redirect_any,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] target;

    // NOTE: every output of a combinational block is given a default first so no latch is inferred.
    always_comb begin
        redirect_any = redirect_valid;
        target       = redirect_addr;
`ifdef FETCH_BRANCH_EN
        // An absolute redirect outranks a branch raised in the same cycle.
        if (!redirect_valid && branch_taken) begin
            redirect_any = 1'b1;
            target       = branch_base + ADDR_W'($signed(branch_offset));
        end
`endif
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (redirect_any) begin
            pc <= target;
        end else if (advance) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: issues memory requests, presents words to the IR,
// handles stall, redirect and drain. Optional branch ports: FETCH_BRANCH_EN.
module fetch_unit #(
    parameter int          ADDR_W   = cpu_pkg::ADDR_W,
    parameter int          INS_W    = cpu_pkg::INS_W,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INS_W-1:0]  imem_rdata,
    output logic [INS_W-1:0]  ins,
    output logic              load_IR,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              stall,
    input  logic              redirect_valid,
`ifdef FETCH_BRANCH_EN
    input  logic              branch_taken,
    input  logic [5:0]        branch_offset,
`endif
    input  logic [ADDR_W-1:0] redirect_addr
);

    import cpu_pkg::*;

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] drain_addr;
    logic              redirect_any;
    logic              advance;
    logic              capture;
    logic              load_q, load_nxt;
    logic              hold_load;

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk            (clk),
        .rst            (rst),
        .advance        (advance),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
`ifdef FETCH_BRANCH_EN
        .branch_taken   (branch_taken),
        .branch_offset  (branch_offset),
        .branch_base    (ins_pc),
`endif
        .redirect_any   (redirect_any),
        .pc             (pc)
    );

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        advance   = 1'b0;
        capture   = 1'b0;
        load_nxt  = 1'b0;
        hold_load = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = run ? FETCH : IDLE;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (redirect_any) begin
                        state_nxt = FETCH;
                    end else begin
                        capture = 1'b1;
                        advance = 1'b1;
                        if (stall) begin
                            state_nxt = HOLD;
                        end else begin
                            load_nxt  = 1'b1;
                            state_nxt = run ? FETCH : IDLE;
                        end
                    end
                end else if (redirect_any) begin
                    state_nxt = DRAIN;
                end
            end
            HOLD: begin
                if (redirect_any) begin
                    state_nxt = run ? FETCH : IDLE;
                end else if (!stall) begin
                    hold_load = 1'b1;
                    state_nxt = run ? FETCH : IDLE;
                end
            end
            DRAIN: begin
                // The old request must still complete; its data is thrown away.
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_addr = (state == DRAIN) ? drain_addr : pc;
    assign load_IR   = load_q | hold_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            load_q     <= 1'b0;
            ins        <= '0;
            ins_pc     <= '0;
            drain_addr <= ADDR_W'(RESET_PC);
        end else begin
            state  <= state_nxt;
            load_q <= load_nxt;
            if (capture) begin
                ins    <= imem_rdata;
                ins_pc <= pc;
            end
            if (state == FETCH && redirect_any && !imem_ack) begin
                drain_addr <= pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a wait-configurable memory model.
module tb_fetch_unit;

    localparam int ADDR_W = 14;
    localparam int INS_W  = 19;

    logic              clk;
    logic              rst;
    logic              run;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INS_W-1:0]  imem_rdata;
    logic [INS_W-1:0]  ins;
    logic              load_IR;
    logic [ADDR_W-1:0] ins_pc;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
`ifdef FETCH_BRANCH_EN
    logic              branch_taken;
    logic [5:0]        branch_offset;
`endif

    logic              model_ack;
    logic [INS_W-1:0]  model_rdata;
    logic              force_ack;
    logic [INS_W-1:0]  force_rdata;
    int                mem_wait;
    int                wait_cnt;
    int                checks;
    int                failures;

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INS_W    (INS_W),
        .RESET_PC (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .ins            (ins),
        .load_IR        (load_IR),
        .ins_pc         (ins_pc),
        .stall          (stall),
        .redirect_valid (redirect_valid),
`ifdef FETCH_BRANCH_EN
        .branch_taken   (branch_taken),
        .branch_offset  (branch_offset),
`endif
        .redirect_addr  (redirect_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers mem_wait cycles after first seeing a request, one-cycle ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            model_ack   <= 1'b0;
            model_rdata <= '0;
            wait_cnt    <= 0;
        end else if (imem_req && !imem_ack) begin
            if (wait_cnt >= mem_wait) begin
                model_ack   <= 1'b1;
                model_rdata <= INS_W'(19'h0A000) | INS_W'(imem_addr);
                wait_cnt    <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            model_ack <= 1'b0;
        end
    end

    assign imem_ack   = model_ack | force_ack;
    assign imem_rdata = force_ack ? force_rdata : model_rdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; run = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0;
        force_ack = 1'b0; force_rdata = '0; mem_wait = 0;
`ifdef FETCH_BRANCH_EN
        branch_taken = 1'b0; branch_offset = '0;
`endif
        tick(); tick();
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_ins", ins, 0);
        check("rst_ins_pc", ins_pc, 0);
        check("rst_load", load_IR, 0);

        // Streaming with a one-cycle memory: one word every second cycle.
        rst = 1'b0; run = 1'b1;
        tick();
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("gap_load", load_IR, 0);
            tick();
            check("stream_load", load_IR, 1);
            check("stream_ins_pc", ins_pc, k);
            check("stream_ins", ins, 32'h0A000 | k);
            check("stream_addr", imem_addr, k + 1);
        end

        // Stall held across the ack of address 4.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_load", load_IR, 0);
            if (i > 0) begin
                check("hold_no_req", imem_req, 0);
                check("hold_ins", ins, 32'h0A004);
            end
        end
        stall = 1'b0;
        #1;
        check("unstall_load", load_IR, 1);
        check("unstall_ins", ins, 32'h0A004);
        check("unstall_ins_pc", ins_pc, 4);
        tick();
        check("after_hold_load", load_IR, 0);
        check("after_hold_req", imem_req, 1);
        check("after_hold_addr", imem_addr, 5);

        // Redirect while a slow request is outstanding.
        mem_wait = 3;
        redirect_valid = 1'b1; redirect_addr = 14'h0100;
        tick();
        redirect_valid = 1'b0;
        check("drain_req", imem_req, 1);
        check("drain_addr", imem_addr, 5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drain_load", load_IR, 0);
            check("drain_addr_hold", imem_addr, 5);
        end
        tick();
        check("redir_addr", imem_addr, 14'h0100);
        check("redir_no_load", load_IR, 0);
        mem_wait = 0;
        tick();
        check("redir_gap", load_IR, 0);
        tick();
        check("redir_load", load_IR, 1);
        check("redir_ins_pc", ins_pc, 14'h0100);
        check("redir_ins", ins, 32'h0A100);

        // Redirect coinciding with an ack drops the response.
        tick();
        check("ack_pending_load", load_IR, 0);
        redirect_valid = 1'b1; redirect_addr = 14'h3FFF;
        tick();
        redirect_valid = 1'b0;
        check("ack_redir_load", load_IR, 0);
        check("ack_redir_addr", imem_addr, 14'h3FFF);
        tick();
        check("wrap_gap", load_IR, 0);
        tick();
        check("wrap_load", load_IR, 1);
        check("wrap_ins_pc", ins_pc, 14'h3FFF);
        check("wrap_ins", ins, 32'h0BFFF);
        check("wrap_addr", imem_addr, 0);

        // Reset in the middle of a memory wait, then a stray ack while idle.
        mem_wait = 3;
        tick(); tick();
        check("prerst_req", imem_req, 1);
        rst = 1'b1;
        #1;
        check("midrst_req", imem_req, 0);
        check("midrst_addr", imem_addr, 0);
        check("midrst_load", load_IR, 0);
        tick();
        rst = 1'b0; run = 1'b0;
        tick();
        force_ack = 1'b1; force_rdata = 19'h12345;
        tick();
        force_ack = 1'b0;
        check("stray_load", load_IR, 0);
        check("stray_req", imem_req, 0);
        tick();
        check("idle_load", load_IR, 0);
        check("idle_req", imem_req, 0);
        check("idle_pc", imem_addr, 0);
        check("idle_ins", ins, 0);
        check("idle_ins_pc", ins_pc, 0);

        // Redirect while idle and stopped only moves the pc.
        redirect_valid = 1'b1; redirect_addr = 14'h0042;
        tick();
        redirect_valid = 1'b0;
        check("idle_redir_req", imem_req, 0);
        check("idle_redir_addr", imem_addr, 14'h0042);

`ifdef FETCH_BRANCH_EN
        mem_wait = 0; run = 1'b1;
        redirect_valid = 1'b1; redirect_addr = 14'h0010;
        tick();
        redirect_valid = 1'b0;
        check("br_setup_addr", imem_addr, 14'h0010);
        tick(); tick();
        check("br_setup_load", load_IR, 1);
        check("br_setup_ins_pc", ins_pc, 14'h0010);
        branch_taken = 1'b1; branch_offset = 6'b111100;
        tick();
        branch_taken = 1'b0;
        check("br_drain_addr", imem_addr, 14'h0011);
        tick();
        check("br_target", imem_addr, 14'h000C);
        tick(); tick();
        check("br_load", load_IR, 1);
        check("br_ins_pc", ins_pc, 14'h000C);
        branch_taken = 1'b1; branch_offset = 6'b111100;
        redirect_valid = 1'b1; redirect_addr = 14'h0200;
        tick();
        branch_taken = 1'b0; redirect_valid = 1'b0;
        tick();
        check("br_prio_addr", imem_addr, 14'h0200);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
